// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] PC_INC = 32'd4;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] npc;
    } fetch_entry_t;

    localparam fetch_entry_t EMPTY_ENTRY = '{instr: NOP, npc: NOP};

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Prefetch FIFO of {instr, npc} entries; clear dominates push and pop.
// The head is presented combinationally and reads as all-zero when empty.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    output logic [$clog2(DEPTH):0] count,
    output logic                   head_valid,
    output fetch_entry_t           head_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   r_mem [DEPTH];
    logic [AW-1:0]  r_rd;
    logic [AW-1:0]  r_wr;
    logic [CW-1:0]  r_count;
    logic           w_pop;

    assign w_pop = pop && (r_count != {CW{1'b0}});

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_rd    <= {AW{1'b0}};
            r_wr    <= {AW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            if (push) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            r_count <= r_count + CW'(push) - CW'(w_pop);
        end
    end

    // Entry storage; data needs no reset because the head is masked when empty.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            r_mem[r_wr] <= push_data;
        end
    end

    // Head view.
    always_comb begin
        count      = r_count;
        head_valid = (r_count != {CW{1'b0}});
        if (head_valid) begin
            head_data = r_mem[r_rd];
        end else begin
            head_data = EMPTY_ENTRY;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding request FSM and prefetch FIFO.
// Optional performance counters are enabled with FETCH_PERF_CNT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_npc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int            CW   = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_state_e  r_state;
    fetch_state_e  w_state_nxt;
    logic [31:0]   r_pc;
    logic [31:0]   w_pc_nxt;
    logic [31:0]   r_addr;
    logic          r_req;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_nxt;
    fetch_entry_t  w_push_data;
    fetch_entry_t  w_head;
    logic          w_head_valid;

    assign w_push      = (r_state == REQ) && imem_ack && !redirect;
    assign w_pop       = w_head_valid && !stall && !redirect;
    assign w_count_nxt = w_count + CW'(w_push) - CW'(w_pop);

    // Entry pushed on a good ack.
    always_comb begin
        w_push_data.instr = imem_rdata;
        w_push_data.npc   = r_pc + PC_INC;
    end

    fetch_buf #(
        .DEPTH(DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .count     (w_count),
        .head_valid(w_head_valid),
        .head_data (w_head)
    );

    // Next-state and next-PC; redirect outranks an ack in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        case (r_state)
            IDLE: begin
                if (redirect) begin
                    w_state_nxt = REQ;
                    w_pc_nxt    = align_pc(redirect_pc);
                end else if (w_count < FULL) begin
                    w_state_nxt = REQ;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            REQ: begin
                if (redirect) begin
                    w_pc_nxt    = align_pc(redirect_pc);
                    w_state_nxt = imem_ack ? REQ : DRAIN;
                end else if (imem_ack) begin
                    w_pc_nxt    = r_pc + PC_INC;
                    w_state_nxt = (w_count_nxt < FULL) ? REQ : IDLE;
                end else begin
                    w_state_nxt = REQ;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    w_pc_nxt = align_pc(redirect_pc);
                end else begin
                    w_pc_nxt = r_pc;
                end
                w_state_nxt = imem_ack ? REQ : DRAIN;
            end
            default: begin
                w_state_nxt = IDLE;
                w_pc_nxt    = r_pc;
            end
        endcase
    end

    // State, PC and request registers; DRAIN keeps the stale address on the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
            r_req   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_req   <= (w_state_nxt != IDLE);
            if (w_state_nxt != DRAIN) begin
                r_addr <= w_pc_nxt;
            end
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_addr;
    assign out_valid = w_head_valid;
    assign out_instr = w_head.instr;
    assign out_npc   = w_head.npc;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;

    // Fetches accepted into the FIFO and cycles a valid head is held by stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetch <= 32'd0;
            r_perf_stall <= 32'd0;
        end else begin
            if (w_push) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (w_head_valid && stall) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random stall/redirect/latency,
// every cycle compared against a queue-based reference model.
module tb_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PAT      = 32'hA5A5_0000;

    logic        clk         = 1'b0;
    logic        rst         = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack    = 1'b0;
    logic [31:0] imem_rdata  = 32'd0;
    logic        redirect    = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        stall       = 1'b0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_npc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    fetch_unit #(
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .stall      (stall),
        .out_valid  (out_valid),
        .out_instr  (out_instr),
        .out_npc    (out_npc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue of {instr, npc}, fetch pointer and request bookkeeping.
    logic [63:0] m_q[$];
    logic [31:0] m_pc      = RESET_PC;
    logic [31:0] m_addr    = RESET_PC;
    bit          m_busy    = 1'b0;
    bit          m_discard = 1'b0;
    logic [31:0] m_fetch   = 32'd0;
    logic [31:0] m_stallc  = 32'd0;

    // Memory model and observation logs.
    int          mem_seen = 0;
    int          mem_lat  = 1;
    bit          lat_rand = 1'b0;
    logic [31:0] pop_log[$];
    logic [31:0] ack_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit s_stall, input bit s_redir, input logic [31:0] s_rpc,
                        input bit s_rst, input bit s_late);
        bit ack;
        bit do_pop;
        int pre_size;
        ack = 1'b0;
        if (s_late) begin
            ack = 1'b1;
        end else if (!s_rst && imem_req === 1'b1) begin
            if (mem_seen >= mem_lat) begin
                ack      = 1'b1;
                mem_seen = 0;
                mem_lat  = lat_rand ? int'($urandom_range(4, 1)) : mem_lat;
                ack_log.push_back(imem_addr);
            end else begin
                mem_seen++;
            end
        end
        if (!s_rst && !s_redir && !s_stall && out_valid === 1'b1) begin
            pop_log.push_back(out_npc);
        end
        rst         = s_rst;
        stall       = s_stall;
        redirect    = s_redir;
        redirect_pc = s_rpc;
        imem_ack    = ack;
        imem_rdata  = ack ? (imem_addr ^ PAT) : 32'($urandom());

        if (s_rst) begin
            m_q.delete();
            m_pc      = RESET_PC;
            m_addr    = RESET_PC;
            m_busy    = 1'b0;
            m_discard = 1'b0;
            m_fetch   = 32'd0;
            m_stallc  = 32'd0;
            mem_seen  = 0;
        end else begin
            pre_size = m_q.size();
            if (pre_size != 0 && s_stall) m_stallc++;
            do_pop = (pre_size != 0) && !s_stall && !s_redir;
            if (s_redir) begin
                m_q.delete();
                m_pc = s_rpc & 32'hFFFF_FFFC;
                if (m_busy && !ack) begin
                    m_discard = 1'b1;
                end else begin
                    m_busy    = 1'b1;
                    m_discard = 1'b0;
                end
            end else begin
                if (do_pop) void'(m_q.pop_front());
                if (!m_busy) begin
                    m_busy = (pre_size < DEPTH);
                end else if (ack && m_discard) begin
                    m_discard = 1'b0;
                end else if (ack) begin
                    m_q.push_back({m_pc ^ PAT, m_pc + 32'd4});
                    m_fetch++;
                    m_pc   = m_pc + 32'd4;
                    m_busy = (m_q.size() < DEPTH);
                end
            end
            if (!m_discard) m_addr = m_pc;
        end

        @(posedge clk);
        #1;
        chk("imem_req", 32'(imem_req), 32'(m_busy));
        chk("imem_addr", imem_addr, m_addr);
        chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        chk("out_instr", out_instr, (m_q.size() != 0) ? m_q[0][63:32] : 32'd0);
        chk("out_npc", out_npc, (m_q.size() != 0) ? m_q[0][31:0] : 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch_cnt", perf_fetch_cnt, m_fetch);
        chk("perf_stall_cnt", perf_stall_cnt, m_stallc);
`endif
    endtask

    task automatic run(input int n, input bit s_stall);
        repeat (n) step(s_stall, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic reset_dut();
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        pop_log.delete();
        ack_log.delete();
    endtask

    initial begin
        int          budget;
        int          r;
        bit          st;
        bit          rd;
        bit          rs;
        logic [31:0] rpc;

        // Straight-line fetch with a 1-cycle memory.
        mem_lat = 1;
        reset_dut();
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_imem_req", 32'(imem_req), 32'd0);
        run(14, 1'b0);
        chk("t1_ack_count", 32'(ack_log.size() >= 3), 32'd1);
        chk("t1_pop_count", 32'(pop_log.size() >= 3), 32'd1);
        if (ack_log.size() >= 3 && pop_log.size() >= 3) begin
            chk("t1_addr0", ack_log[0], 32'd0);
            chk("t1_addr1", ack_log[1], 32'd4);
            chk("t1_addr2", ack_log[2], 32'd8);
            chk("t1_npc0", pop_log[0], 32'd4);
            chk("t1_npc1", pop_log[1], 32'd8);
            chk("t1_npc2", pop_log[2], 32'd12);
        end

        // Long stall fills the FIFO and idles the FSM.
        reset_dut();
        run(10, 1'b1);
        chk("t2_req_dropped", 32'(imem_req), 32'd0);
        chk("t2_head_npc", out_npc, 32'd4);
        chk("t2_head_instr", out_instr, PAT);
        ack_log.delete();
        run(8, 1'b0);
        chk("t2_pop_count", 32'(pop_log.size() >= 2), 32'd1);
        chk("t2_resume_count", 32'(ack_log.size() >= 1), 32'd1);
        if (pop_log.size() >= 2 && ack_log.size() >= 1) begin
            chk("t2_drain0", pop_log[0], 32'd4);
            chk("t2_drain1", pop_log[1], 32'd8);
            chk("t2_resume_addr", ack_log[0], 32'd8);
        end

        // Redirect while a 3-cycle request is outstanding.
        reset_dut();
        mem_lat = 3;
        budget  = 0;
        while (!(imem_req === 1'b1 && imem_addr === 32'd8) && budget < 40) begin
            step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
            budget++;
        end
        chk("t3_reached_req8", 32'(budget < 40), 32'd1);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
        chk("t3_drain_addr", imem_addr, 32'd8);
        chk("t3_drain_req", 32'(imem_req), 32'd1);
        ack_log.delete();
        pop_log.delete();
        run(20, 1'b0);
        if (ack_log.size() >= 2 && pop_log.size() >= 1) begin
            chk("t3_stale_ack", ack_log[0], 32'd8);
            chk("t3_new_addr", ack_log[1], 32'h0000_0100);
            chk("t3_first_npc", pop_log[0], 32'h0000_0104);
        end else begin
            chk("t3_progress", 32'd0, 32'd1);
        end

        // Redirect in the same cycle as an ack and a pop.
        reset_dut();
        mem_lat = 1;
        budget  = 0;
        while (!(out_valid === 1'b1 && imem_req === 1'b1 && mem_seen >= mem_lat) && budget < 40) begin
            step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
            budget++;
        end
        chk("t4_reached", 32'(budget < 40), 32'd1);
        step(1'b0, 1'b1, 32'h0000_0200, 1'b0, 1'b0);
        chk("t4_valid_cleared", 32'(out_valid), 32'd0);
        chk("t4_new_addr", imem_addr, 32'h0000_0200);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("t4_valid_next", 32'(out_valid), 32'd0);

        // PC wrap at the top of the address space.
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        pop_log.delete();
        ack_log.delete();
        run(10, 1'b0);
        if (ack_log.size() >= 2 && pop_log.size() >= 1) begin
            chk("t5_top_addr", ack_log[0], 32'hFFFF_FFFC);
            chk("t5_wrap_addr", ack_log[1], 32'd0);
            chk("t5_wrap_npc", pop_log[0], 32'd0);
        end else begin
            chk("t5_progress", 32'd0, 32'd1);
        end

        // Unaligned redirect target is word-aligned.
        reset_dut();
        step(1'b0, 1'b1, 32'h0000_0043, 1'b0, 1'b0);
        chk("t5_align_addr", imem_addr, 32'h0000_0040);

        // Reset mid-request, then a late ack.
        reset_dut();
        mem_lat = 1;
        run(3, 1'b1);
        chk("t6_pre_req", 32'(imem_req), 32'd1);
        mem_lat = 3;
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("t6_rst_req", 32'(imem_req), 32'd0);
        chk("t6_rst_addr", imem_addr, RESET_PC);
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_instr", out_instr, 32'd0);
        chk("t6_rst_npc", out_npc, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        chk("t6_late_ack_ignored", 32'(out_valid), 32'd0);
        run(6, 1'b0);

`ifdef FETCH_PERF_CNT_EN
        // Five fetches and three stalled-valid cycles.
        reset_dut();
        mem_lat = 1;
        run(9, 1'b0);
        run(3, 1'b1);
        chk("t7_perf_fetch", perf_fetch_cnt, 32'd5);
        chk("t7_perf_stall", perf_stall_cnt, 32'd3);
`endif

        // Random mix of stall, redirect, latency and occasional reset.
        reset_dut();
        lat_rand = 1'b1;
        mem_lat  = 2;
        for (int i = 0; i < 3000; i++) begin
            r   = int'($urandom_range(99, 0));
            st  = ($urandom_range(9, 0) < 3);
            rd  = (r < 5);
            rs  = (r == 50);
            rpc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                              : 32'($urandom());
            step(st, rd, rpc, rs, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
